// File: rtl/tile_gray_rx.sv
// tile_gray_rx
// Receives the per-tile peak-gray scan stream. Each stream entry is a tile
// index plus that tile's gray value. The block locks onto index 0 and then
// follows the indices in order. It buffers one complete sweep of the 24x15
// tile grid. During capture it keeps a running brightest tile and a count of
// tiles above the threshold. The result is frozen in HOLD until downstream
// acknowledges it.

module tile_gray_rx #(
  parameter int N_TILES       = 360,
  parameter int TILES_PER_ROW = 24
) (
  input  logic        clk,
  input  logic        I_rst_n,
  input  logic        I_valid,
  input  logic [9:0]  I_data,
  input  logic [15:0] I_gray,
  input  logic [15:0] I_thresh,
  input  logic        I_frame_ack,
  input  logic [8:0]  I_rd_addr,
  output logic [15:0] O_rd_data,
  output logic        O_frame_valid,
  output logic [9:0]  O_max_idx,
  output logic [3:0]  O_max_row,
  output logic [4:0]  O_max_col,
  output logic [15:0] O_max_gray,
  output logic [8:0]  O_hot_cnt,
  output logic        O_seq_err
);

  localparam logic [9:0] LAST_IDX  = 10'(N_TILES - 1);
  localparam logic [8:0] RD_LIMIT  = 9'(N_TILES);
  localparam logic [4:0] LAST_COL  = 5'(TILES_PER_ROW - 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Control decisions for the current stream entry
  logic       start_sweep;
  logic       take_pair;
  logic       last_pair;
  logic       seq_err_next;
  logic       buf_we;
  logic [8:0] buf_waddr;

  // Sweep bookkeeping: sampled threshold, expected index and its grid position
  logic [15:0] thresh_q;
  logic [9:0]  exp_idx;
  logic [3:0]  row_cnt;
  logic [4:0]  col_cnt;

  // Running results for the sweep in progress
  logic [9:0]  run_idx;
  logic [3:0]  run_row;
  logic [4:0]  run_col;
  logic [15:0] run_gray;
  logic [8:0]  run_hot;

  // Running results with the current entry folded in
  logic        new_max;
  logic        gray_hot;
  logic [9:0]  cand_idx;
  logic [3:0]  cand_row;
  logic [4:0]  cand_col;
  logic [15:0] cand_gray;
  logic [8:0]  cand_hot;

  // The sweep buffer is not reset; its contents only matter once a sweep is complete
  logic [15:0] buf_mem [0:N_TILES-1];

  // State register; reset returns to hunting for index 0
  always_ff @(posedge clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and per-entry decisions (start, accept, continuity break)
  always_comb begin
    state_next   = state;
    start_sweep  = 1'b0;
    take_pair    = 1'b0;
    last_pair    = 1'b0;
    seq_err_next = 1'b0;
    case (state)
      HUNT: begin
        if (I_valid && (I_data == 10'd0)) begin
          start_sweep = 1'b1;
          state_next  = CAPTURE;
        end
      end
      CAPTURE: begin
        if (I_valid) begin
          if (I_data == exp_idx) begin
            take_pair = 1'b1;
            if (exp_idx == LAST_IDX) begin
              last_pair  = 1'b1;
              state_next = HOLD;
            end
          end else begin
            seq_err_next = 1'b1;
            if (I_data == 10'd0) begin
              start_sweep = 1'b1;
            end else begin
              state_next = HUNT;
            end
          end
        end
      end
      HOLD: begin
        if (I_frame_ack) begin
          state_next = HUNT;
        end
      end
      default: begin
        state_next = HUNT;
      end
    endcase
    buf_we    = start_sweep | take_pair;
    buf_waddr = start_sweep ? 9'd0 : exp_idx[8:0];
  end

  // Fold the incoming gray into the running max and hot count (strict > keeps lowest index on ties)
  always_comb begin
    new_max   = I_gray > run_gray;
    gray_hot  = I_gray > thresh_q;
    cand_idx  = new_max ? exp_idx : run_idx;
    cand_row  = new_max ? row_cnt : run_row;
    cand_col  = new_max ? col_cnt : run_col;
    cand_gray = new_max ? I_gray  : run_gray;
    cand_hot  = run_hot + {8'd0, gray_hot};
  end

  // Sweep bookkeeping and running results; index 0 seeds everything
  always_ff @(posedge clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      thresh_q <= '0;
      exp_idx  <= '0;
      row_cnt  <= '0;
      col_cnt  <= '0;
      run_idx  <= '0;
      run_row  <= '0;
      run_col  <= '0;
      run_gray <= '0;
      run_hot  <= '0;
    end else if (start_sweep) begin
      thresh_q <= I_thresh;
      exp_idx  <= 10'd1;
      row_cnt  <= 4'd0;
      col_cnt  <= 5'd1;
      run_idx  <= 10'd0;
      run_row  <= 4'd0;
      run_col  <= 5'd0;
      run_gray <= I_gray;
      run_hot  <= {8'd0, (I_gray > I_thresh)};
    end else if (take_pair) begin
      exp_idx  <= exp_idx + 10'd1;
      run_idx  <= cand_idx;
      run_row  <= cand_row;
      run_col  <= cand_col;
      run_gray <= cand_gray;
      run_hot  <= cand_hot;
      if (col_cnt == LAST_COL) begin
        col_cnt <= 5'd0;
        row_cnt <= row_cnt + 4'd1;
      end else begin
        col_cnt <= col_cnt + 5'd1;
      end
    end
  end

  // Published results change only when the last tile of a clean sweep arrives
  always_ff @(posedge clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_max_idx  <= '0;
      O_max_row  <= '0;
      O_max_col  <= '0;
      O_max_gray <= '0;
      O_hot_cnt  <= '0;
    end else if (last_pair) begin
      O_max_idx  <= cand_idx;
      O_max_row  <= cand_row;
      O_max_col  <= cand_col;
      O_max_gray <= cand_gray;
      O_hot_cnt  <= cand_hot;
    end
  end

  // One-cycle registered pulse per out-of-order entry during capture
  always_ff @(posedge clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_seq_err <= 1'b0;
    end else begin
      O_seq_err <= seq_err_next;
    end
  end

  // Sweep buffer write; never written in HOLD, so it stays frozen while the result is valid
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_mem[buf_waddr] <= I_gray;
    end
  end

  // Registered random-access read; addresses past the last tile read as zero
  always_ff @(posedge clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_rd_data <= '0;
    end else if (I_rd_addr < RD_LIMIT) begin
      O_rd_data <= buf_mem[I_rd_addr];
    end else begin
      O_rd_data <= '0;
    end
  end

  assign O_frame_valid = (state == HOLD);

endmodule

// File: tb/tb_tile_gray_rx.sv
// tb_tile_gray_rx
// Drives tile_gray_rx with directed and randomized scan streams. A
// sweep-level reference model (a queue of accepted grays plus plain
// max/count arithmetic) provides every expected output.

module tb_tile_gray_rx;

  logic        clk = 1'b0;
  logic        I_rst_n;
  logic        I_valid;
  logic [9:0]  I_data;
  logic [15:0] I_gray;
  logic [15:0] I_thresh;
  logic        I_frame_ack;
  logic [8:0]  I_rd_addr;
  logic [15:0] O_rd_data;
  logic        O_frame_valid;
  logic [9:0]  O_max_idx;
  logic [3:0]  O_max_row;
  logic [4:0]  O_max_col;
  logic [15:0] O_max_gray;
  logic [8:0]  O_hot_cnt;
  logic        O_seq_err;

  int checks = 0;
  int errors = 0;

  // Reference model: capture status, accepted grays, buffer image, expected results
  bit          m_capturing;
  bit          m_holding;
  bit          m_err;
  logic [15:0] m_thresh;
  logic [15:0] m_q [$];
  logic [15:0] m_buf [0:359];
  logic [9:0]  e_idx;
  logic [3:0]  e_row;
  logic [4:0]  e_col;
  logic [15:0] e_gray;
  logic [8:0]  e_hot;
  bit          rd_known;
  logic [15:0] e_rd;
  logic [15:0] gen_gray [0:359];

  // 10 ns system clock
  always #5 clk = ~clk;

  tile_gray_rx #(
    .N_TILES       (360),
    .TILES_PER_ROW (24)
  ) dut (
    .clk           (clk),
    .I_rst_n       (I_rst_n),
    .I_valid       (I_valid),
    .I_data        (I_data),
    .I_gray        (I_gray),
    .I_thresh      (I_thresh),
    .I_frame_ack   (I_frame_ack),
    .I_rd_addr     (I_rd_addr),
    .O_rd_data     (O_rd_data),
    .O_frame_valid (O_frame_valid),
    .O_max_idx     (O_max_idx),
    .O_max_row     (O_max_row),
    .O_max_col     (O_max_col),
    .O_max_gray    (O_max_gray),
    .O_hot_cnt     (O_hot_cnt),
    .O_seq_err     (O_seq_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_capturing = 1'b0;
    m_holding   = 1'b0;
    m_err       = 1'b0;
    m_q.delete();
    e_idx  = '0;
    e_row  = '0;
    e_col  = '0;
    e_gray = '0;
    e_hot  = '0;
  endfunction

  function automatic void model_start(input logic [15:0] g);
    m_q.delete();
    m_q.push_back(g);
    m_thresh    = I_thresh;
    m_buf[0]    = g;
    m_capturing = 1'b1;
  endfunction

  // Result of a complete sweep: first brightest tile, its grid position, hot count
  function automatic void model_results();
    int best = 0;
    int hot  = 0;
    for (int i = 0; i < 360; i++) begin
      if (m_q[i] > m_q[best]) best = i;
      if (m_q[i] > m_thresh) hot++;
    end
    e_idx  = 10'(best);
    e_row  = 4'(best / 24);
    e_col  = 5'(best % 24);
    e_gray = m_q[best];
    e_hot  = 9'(hot);
  endfunction

  function automatic void model_step(input bit v, input int d, input logic [15:0] g, input bit ack);
    m_err = 1'b0;
    if (m_holding) begin
      if (ack) m_holding = 1'b0;
    end else if (m_capturing) begin
      if (v) begin
        if (d == m_q.size()) begin
          m_buf[d] = g;
          m_q.push_back(g);
          if (m_q.size() == 360) begin
            model_results();
            m_holding   = 1'b1;
            m_capturing = 1'b0;
          end
        end else begin
          m_err = 1'b1;
          if (d == 0) model_start(g);
          else m_capturing = 1'b0;
        end
      end
    end else if (v && d == 0) begin
      model_start(g);
    end
  endfunction

  task automatic checkOutput();
    check("frame_valid", O_frame_valid, m_holding);
    check("seq_err", O_seq_err, m_err);
    check("max_idx", O_max_idx, e_idx);
    check("max_row", O_max_row, e_row);
    check("max_col", O_max_col, e_col);
    check("max_gray", O_max_gray, e_gray);
    check("hot_cnt", O_hot_cnt, e_hot);
    if (rd_known) check("rd_data", O_rd_data, e_rd);
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, check 1 ns later
  task automatic applyStimulus(input bit v, input int d, input logic [15:0] g, input bit ack, input int addr);
    bit was_holding;
    I_valid     = v;
    I_data      = 10'(d);
    I_gray      = g;
    I_frame_ack = ack;
    I_rd_addr   = 9'(addr);
    @(posedge clk);
    was_holding = m_holding;
    model_step(v, d, g, ack);
    rd_known = was_holding || (addr >= 360);
    e_rd     = (addr >= 360) ? 16'd0 : m_buf[addr];
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, int'($urandom_range(0, 1023)), 16'($urandom), 1'b0, int'($urandom_range(0, 511)));
  endtask

  // Send indices lo..hi in order with gen_gray values, optionally with random idle gaps
  task automatic send_run(input int lo, input int hi, input bit gaps);
    for (int i = lo; i <= hi; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle(1);
      applyStimulus(1'b1, i, gen_gray[i], 1'b0, int'($urandom_range(0, 511)));
    end
  endtask

  task automatic randomize_grays();
    for (int i = 0; i < 360; i++) gen_gray[i] = 16'($urandom);
  endtask

  task automatic ack_frame();
    applyStimulus(1'b0, 0, 16'd0, 1'b1, 400);
  endtask

  initial begin
    I_rst_n     = 1'b0;
    I_valid     = 1'b0;
    I_data      = '0;
    I_gray      = '0;
    I_thresh    = '0;
    I_frame_ack = 1'b0;
    I_rd_addr   = '0;
    model_reset();
    rd_known = 1'b1;
    e_rd     = 16'd0;

    // Reset state
    #12;
    checkOutput();
    @(negedge clk);
    I_rst_n = 1'b1;
    $display("[TB] reset released");

    // Ramp sweep: gray = idx*10, threshold 1000
    I_thresh = 16'd1000;
    for (int i = 0; i < 360; i++) gen_gray[i] = 16'(i * 10);
    send_run(0, 359, 1'b0);
    check("ramp_frame_valid", O_frame_valid, 1);
    check("ramp_max_idx", O_max_idx, 359);
    check("ramp_max_row", O_max_row, 14);
    check("ramp_max_col", O_max_col, 23);
    check("ramp_max_gray", O_max_gray, 3590);
    check("ramp_hot_cnt", O_hot_cnt, 259);

    // Read port in HOLD, including an out-of-range address
    applyStimulus(1'b0, 0, 16'd0, 1'b0, 0);
    check("rd_addr0", O_rd_data, 0);
    applyStimulus(1'b0, 0, 16'd0, 1'b0, 359);
    check("rd_addr359", O_rd_data, 3590);
    applyStimulus(1'b0, 0, 16'd0, 1'b0, 400);
    check("rd_addr400", O_rd_data, 0);

    // A new sweep arriving during HOLD must not disturb anything
    randomize_grays();
    send_run(0, 50, 1'b0);
    applyStimulus(1'b0, 0, 16'd0, 1'b0, 10);
    check("hold_frozen_rd10", O_rd_data, 100);
    check("hold_frozen_max", O_max_gray, 3590);

    // Ack together with an index-0 pair: the pair is ignored
    applyStimulus(1'b1, 0, 16'h1234, 1'b1, 0);
    check("ack_drops_valid", O_frame_valid, 0);
    send_run(1, 30, 1'b0);
    idle(3);

    // Stream joins mid-sweep at 200; capture starts at the wrap
    I_thresh = 16'($urandom_range(0, 1000));
    for (int i = 0; i < 360; i++) gen_gray[i] = 16'd5;
    gen_gray[50] = 16'd900;
    send_run(200, 359, 1'b0);
    send_run(0, 359, 1'b0);
    check("join_max_idx", O_max_idx, 50);
    check("join_max_row", O_max_row, 2);
    check("join_max_col", O_max_col, 2);
    check("join_max_gray", O_max_gray, 900);
    ack_frame();

    // All tiles equal: lowest index wins, nothing is strictly above the threshold
    I_thresh = 16'd7777;
    for (int i = 0; i < 360; i++) gen_gray[i] = 16'd7777;
    send_run(0, 359, 1'b1);
    check("tie_max_idx", O_max_idx, 0);
    check("tie_max_gray", O_max_gray, 7777);
    check("tie_hot_cnt", O_hot_cnt, 0);
    ack_frame();

    // Skipped index: one error pulse, back to HUNT
    I_thresh = 16'($urandom);
    randomize_grays();
    send_run(0, 99, 1'b1);
    applyStimulus(1'b1, 101, gen_gray[101], 1'b0, 0);
    check("skip_seq_err", O_seq_err, 1);
    applyStimulus(1'b1, 102, gen_gray[102], 1'b0, 0);
    check("skip_err_once", O_seq_err, 0);
    send_run(103, 359, 1'b0);
    check("skip_no_frame", O_frame_valid, 0);

    // Stray index 5 then 0; index 0 out of order restarts; index >= 360 aborts
    send_run(0, 40, 1'b1);
    applyStimulus(1'b1, 5, 16'($urandom), 1'b0, 0);
    applyStimulus(1'b1, 0, gen_gray[0], 1'b0, 0);
    send_run(1, 60, 1'b0);
    applyStimulus(1'b1, 0, gen_gray[0], 1'b0, 0);
    check("restart_seq_err", O_seq_err, 1);
    send_run(1, 20, 1'b0);
    applyStimulus(1'b1, 1000, 16'($urandom), 1'b0, 0);
    check("range_seq_err", O_seq_err, 1);
    send_run(21, 40, 1'b0);
    send_run(0, 359, 1'b1);
    check("clean_frame_valid", O_frame_valid, 1);
    for (int k = 0; k < 6; k++) applyStimulus(1'b0, 0, 16'd0, 1'b0, int'($urandom_range(0, 511)));
    ack_frame();

    // Reset in the middle of a capture
    randomize_grays();
    I_thresh = 16'($urandom);
    send_run(0, 180, 1'b0);
    I_rst_n = 1'b0;
    #1;
    model_reset();
    rd_known = 1'b1;
    e_rd     = 16'd0;
    checkOutput();
    @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
    I_rst_n = 1'b1;
    randomize_grays();
    send_run(0, 359, 1'b1);
    check("post_reset_frame", O_frame_valid, 1);
    for (int k = 0; k < 6; k++) applyStimulus(1'b0, 0, 16'd0, 1'b0, int'($urandom_range(0, 359)));
    ack_frame();

    // A few fully random sweeps with random thresholds
    for (int s = 0; s < 3; s++) begin
      I_thresh = 16'($urandom);
      randomize_grays();
      send_run(0, 359, 1'b1);
      for (int k = 0; k < 4; k++) applyStimulus(1'b0, 0, 16'd0, 1'b0, int'($urandom_range(0, 511)));
      ack_frame();
      idle(2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
